// File: rtl/pmem_pkg.sv
// Shared types and constants for the pmem responder slice.
package pmem_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } pmem_op_e;

endpackage

// File: rtl/pmem_line_array.sv
// Single-port LINES x 256-bit line storage: write-enable, registered read, no reset.
module pmem_line_array
  import pmem_pkg::*;
#(
  parameter int LINES = 256,
  localparam int AW = $clog2(LINES)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [LINE_WIDTH-1:0] wdata,
  output logic [LINE_WIDTH-1:0] rdata
);

  // Power-up contents are zero so reads of never-written lines are defined.
  logic [LINE_WIDTH-1:0] mem [LINES] = '{default: '0};

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Line-level physical-memory responder with programmable latency.
// Optional protocol checker (proto_err port) enabled by PMEM_PROTOCOL_CHECK_EN.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int LINES   = 256,
  parameter int LATENCY = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
`ifdef PMEM_PROTOCOL_CHECK_EN
  output logic                  proto_err,
`endif
  output logic [1:0]            dbg_state
);

  // Handshake: a request (read or write) is held from IDLE until the single
  // pmem_resp cycle; inputs are sampled only in IDLE, the write wins a tie.
  localparam int AW = $clog2(LINES);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  pmem_state_e           state_q, state_d;
  logic [CW-1:0]         cnt_q;
  pmem_op_e              op_q;
  logic [AW-1:0]         idx_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  rd_valid_q;

  logic                  req, enter_resp, arr_en;
  pmem_op_e              in_op, cur_op;
  logic [AW-1:0]         in_idx, cur_idx;
  logic [LINE_WIDTH-1:0] cur_wdata, arr_rdata;
  logic                  unused_addr_bits;

  assign req              = pmem_read | pmem_write;
  assign in_op            = pmem_write ? OP_WRITE : OP_READ;
  assign in_idx           = pmem_address[OFFSET_BITS +: AW];
  assign unused_addr_bits = ^pmem_address;

  // With LATENCY=1 the array access happens on the acceptance edge itself,
  // so the live inputs are used instead of the latched copies.
  assign cur_op     = (state_q == IDLE) ? in_op      : op_q;
  assign cur_idx    = (state_q == IDLE) ? in_idx     : idx_q;
  assign cur_wdata  = (state_q == IDLE) ? pmem_wdata : wdata_q;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);
  assign arr_en     = enter_resp & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // cnt_q counts remaining BUSY cycles; RESP follows when it reaches 1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = (LATENCY == 1) ? RESP : BUSY;
      BUSY:    if (cnt_q <= CW'(1)) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pmem_resp  = (state_q == RESP);
    dbg_state  = state_q;
    pmem_rdata = rd_valid_q ? arr_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      op_q       <= OP_READ;
      idx_q      <= '0;
      wdata_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req) begin
        op_q    <= in_op;
        idx_q   <= in_idx;
        wdata_q <= pmem_wdata;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (arr_en && cur_op == OP_READ) rd_valid_q <= 1'b1;
    end
  end

  pmem_line_array #(.LINES(LINES)) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (cur_op == OP_WRITE),
    .addr  (cur_idx),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [31-OFFSET_BITS:0] addr_hi_q;
  logic                    req_held, err_d;

  assign req_held = (op_q == OP_WRITE) ? pmem_write : (pmem_read & ~pmem_write);

  always_comb begin
    err_d = 1'b0;
    if (state_q == IDLE)
      err_d = pmem_read & pmem_write;
    else if (state_q == BUSY)
      err_d = ~req_held || (pmem_address[31:OFFSET_BITS] != addr_hi_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proto_err <= 1'b0;
      addr_hi_q <= '0;
    end else begin
      if (state_q == IDLE && req) addr_hi_q <= pmem_address[31:OFFSET_BITS];
      if (err_d) proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: instance 0 uses LATENCY=10, instance 1 LATENCY=1.
module tb_pmem_responder;

  logic         clk = 1'b0;
  logic         rst   [2];
  logic [31:0]  addr  [2];
  logic [255:0] wdata [2];
  logic         rd    [2];
  logic         wr    [2];
  logic [255:0] rdata [2];
  logic         resp  [2];
  logic [1:0]   dbg   [2];
`ifdef PMEM_PROTOCOL_CHECK_EN
  logic         perr  [2];
`endif

  // Reference model: line contents and last completed read, per instance.
  logic [255:0] mem_m   [2][256];
  logic [255:0] last_rd [2];
  logic [255:0] exp_q [$];
  int           lat_exp [2] = '{10, 1};
  int           compared = 0;
  int           mismatched = 0;

  always #5 clk = ~clk;

  pmem_responder #(.LINES(256), .LATENCY(10)) dut_l10 (
    .clk(clk), .rst(rst[0]), .pmem_address(addr[0]), .pmem_wdata(wdata[0]),
    .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_rdata(rdata[0]), .pmem_resp(resp[0]),
`ifdef PMEM_PROTOCOL_CHECK_EN
    .proto_err(perr[0]),
`endif
    .dbg_state(dbg[0])
  );

  pmem_responder #(.LINES(256), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst[1]), .pmem_address(addr[1]), .pmem_wdata(wdata[1]),
    .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_rdata(rdata[1]), .pmem_resp(resp[1]),
`ifdef PMEM_PROTOCOL_CHECK_EN
    .proto_err(perr[1]),
`endif
    .dbg_state(dbg[1])
  );

  function automatic int line_of(input logic [31:0] a);
    return int'(a[12:5]);
  endfunction

  // Driver: called at a negedge; returns at the negedge of the IDLE cycle after resp.
  task automatic do_txn(input int d, input bit is_wr, input bit both, input logic [31:0] a,
                        input logic [255:0] wd, input bit scramble, output int lat,
                        output logic [255:0] rd_at_resp, output logic resp_after);
    addr[d]  = a;
    wdata[d] = wd;
    wr[d]    = is_wr;
    rd[d]    = !is_wr || both;
    lat      = -1;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk); @(negedge clk);
      if (resp[d]) begin lat = n; break; end
      if (scramble) begin
        addr[d]  = $urandom;
        wdata[d] = {8{$urandom}};
      end
    end
    rd_at_resp = rdata[d];
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    resp_after = resp[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      last_rd[d] = '0;
      for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      compared++;
      if (resp[d] !== 1'b0) begin mismatched++; $display("FAIL reset_resp[%0d]: got %b want 0", d, resp[d]); end
      compared++;
      if (rdata[d] !== 256'h0) begin mismatched++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rdata[d]); end
      compared++;
      if (dbg[d] !== 2'd0) begin mismatched++; $display("FAIL reset_state[%0d]: got %0d want 0 (IDLE)", d, dbg[d]); end
    end
  endtask

  task automatic test_basic_read();
    int lat; logic [255:0] r; logic ra;
    do_txn(0, 1'b0, 1'b0, 32'h0000_0040, '0, 1'b0, lat, r, ra);
    compared++;
    if (lat !== 10) begin mismatched++; $display("FAIL basic_read_latency: got %0d want 10", lat); end
    compared++;
    if (ra !== 1'b0) begin mismatched++; $display("FAIL basic_read_resp_width: resp still %b a cycle later, want 0", ra); end
    compared++;
    if (r !== 256'h0) begin mismatched++; $display("FAIL basic_read_data: got %h want 0", r); end
  endtask

  task automatic test_write_read();
    int lat; logic [255:0] r; logic ra;
    logic [255:0] pat = {8{32'hDEADBEEF}};
    do_txn(0, 1'b1, 1'b0, 32'h0000_0060, pat, 1'b0, lat, r, ra);
    mem_m[0][line_of(32'h60)] = pat;
    compared++;
    if (lat !== 10) begin mismatched++; $display("FAIL write_latency: got %0d want 10", lat); end
    compared++;
    if (r !== last_rd[0]) begin mismatched++; $display("FAIL write_keeps_rdata: got %h want %h", r, last_rd[0]); end
    exp_q.push_back(mem_m[0][line_of(32'h7C)]);
    do_txn(0, 1'b0, 1'b0, 32'h0000_007C, '0, 1'b0, lat, r, ra);
    last_rd[0] = exp_q.pop_front();
    compared++;
    if (r !== last_rd[0]) begin mismatched++; $display("FAIL write_then_read: got %h want %h", r, last_rd[0]); end
    compared++;
    if (rdata[0] !== last_rd[0]) begin mismatched++; $display("FAIL rdata_stable: got %h want %h", rdata[0], last_rd[0]); end
  endtask

  task automatic test_latency_one();
    int lat; logic [255:0] r; logic ra;
    logic [255:0] pat = {8{32'h0BAD_F00D}};
    do_txn(1, 1'b0, 1'b0, 32'h0000_0020, '0, 1'b0, lat, r, ra);
    last_rd[1] = mem_m[1][1];
    compared++;
    if (lat !== 1) begin mismatched++; $display("FAIL l1_read_latency: got %0d want 1", lat); end
    compared++;
    if (ra !== 1'b0) begin mismatched++; $display("FAIL l1_resp_width: got %b want 0", ra); end
    do_txn(1, 1'b1, 1'b0, 32'h0000_0020, pat, 1'b0, lat, r, ra);
    mem_m[1][1] = pat;
    compared++;
    if (lat !== 1) begin mismatched++; $display("FAIL l1_back_to_back_write_latency: got %0d want 1", lat); end
    do_txn(1, 1'b0, 1'b0, 32'h0000_0020, '0, 1'b0, lat, r, ra);
    last_rd[1] = mem_m[1][1];
    compared++;
    if (r !== pat) begin mismatched++; $display("FAIL l1_readback: got %h want %h", r, pat); end
  endtask

  task automatic test_alias();
    int lat; logic [255:0] r; logic ra;
    logic [255:0] pat = {8{32'h1234_5678}};
    do_txn(0, 1'b1, 1'b0, 32'h0000_2000, pat, 1'b0, lat, r, ra);
    mem_m[0][0] = pat;
    do_txn(0, 1'b0, 1'b0, 32'h0000_0000, '0, 1'b0, lat, r, ra);
    last_rd[0] = mem_m[0][0];
    compared++;
    if (r !== pat) begin mismatched++; $display("FAIL alias_read: got %h want %h", r, pat); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [255:0] r; logic ra; bit saw = 1'b0;
    logic [255:0] old_pat = {8{32'hA5A5_0001}};
    do_txn(0, 1'b1, 1'b0, 32'h0000_0080, old_pat, 1'b0, lat, r, ra);
    mem_m[0][4] = old_pat;
    addr[0] = 32'h0000_0080; wdata[0] = {8{32'h5A5A_0002}}; wr[0] = 1'b1;
    repeat (4) begin @(posedge clk); @(negedge clk); if (resp[0]) saw = 1'b1; end
    rst[0] = 1'b1; wr[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    if (resp[0]) saw = 1'b1;
    rst[0] = 1'b0;
    last_rd[0] = '0;
    repeat (12) begin @(posedge clk); @(negedge clk); if (resp[0]) saw = 1'b1; end
    compared++;
    if (saw !== 1'b0) begin mismatched++; $display("FAIL abort_no_resp: resp seen %b want 0", saw); end
    compared++;
    if (rdata[0] !== 256'h0) begin mismatched++; $display("FAIL abort_rdata_reset: got %h want 0", rdata[0]); end
    do_txn(0, 1'b0, 1'b0, 32'h0000_0080, '0, 1'b0, lat, r, ra);
    last_rd[0] = mem_m[0][4];
    compared++;
    if (r !== old_pat) begin mismatched++; $display("FAIL abort_old_data: got %h want %h", r, old_pat); end
  endtask

`ifdef PMEM_PROTOCOL_CHECK_EN
  task automatic test_proto();
    int lat; logic [255:0] r; logic ra;
    logic [255:0] pat = {8{32'hC0DE_0003}};
    compared++;
    if (perr[0] !== 1'b0) begin mismatched++; $display("FAIL proto_clean_start: got %b want 0", perr[0]); end
    do_txn(0, 1'b1, 1'b1, 32'h0000_0100, pat, 1'b0, lat, r, ra);
    mem_m[0][8] = pat;
    compared++;
    if (perr[0] !== 1'b1) begin mismatched++; $display("FAIL proto_both_flag: got %b want 1", perr[0]); end
    compared++;
    if (r !== last_rd[0]) begin mismatched++; $display("FAIL proto_read_dropped: got %h want %h", r, last_rd[0]); end
    do_txn(0, 1'b0, 1'b0, 32'h0000_0100, '0, 1'b0, lat, r, ra);
    last_rd[0] = pat;
    compared++;
    if (r !== pat) begin mismatched++; $display("FAIL proto_write_won: got %h want %h", r, pat); end
    compared++;
    if (perr[0] !== 1'b1) begin mismatched++; $display("FAIL proto_sticky: got %b want 1", perr[0]); end
    rst[0] = 1'b1; @(negedge clk); rst[0] = 1'b0; @(negedge clk);
    last_rd[0] = '0;
    compared++;
    if (perr[0] !== 1'b0) begin mismatched++; $display("FAIL proto_cleared: got %b want 0", perr[0]); end
  endtask
`endif

  // Random mixed traffic on both instances, with inputs scrambled while busy.
  task automatic test_random();
    int lat; logic [255:0] r, wd; logic ra; logic [31:0] a; bit is_wr;
    for (int d = 0; d < 2; d++) begin
      for (int t = 0; t < 40; t++) begin
        a     = ($urandom & 32'hFFFF_E000) | (32'($urandom_range(0, 15)) << 5) | 32'($urandom_range(0, 31));
        is_wr = $urandom_range(0, 1);
        wd    = {8{$urandom}};
        if (!is_wr) exp_q.push_back(mem_m[d][line_of(a)]);
        do_txn(d, is_wr, 1'b0, a, wd, 1'b1, lat, r, ra);
        if (is_wr) mem_m[d][line_of(a)] = wd;
        else       last_rd[d] = exp_q.pop_front();
        compared++;
        if (lat !== lat_exp[d]) begin mismatched++; $display("FAIL rand_latency[%0d.%0d]: got %0d want %0d", d, t, lat, lat_exp[d]); end
        compared++;
        if (r !== last_rd[d]) begin mismatched++; $display("FAIL rand_rdata[%0d.%0d]: got %h want %h", d, t, r, last_rd[d]); end
        compared++;
        if (ra !== 1'b0) begin mismatched++; $display("FAIL rand_resp_width[%0d.%0d]: got %b want 0", d, t, ra); end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_read();
    test_write_read();
    test_latency_one();
    test_alias();
    test_reset_abort();
`ifdef PMEM_PROTOCOL_CHECK_EN
    test_proto();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
